lsu_access_ctrl: RTL
====================

Name: lsu_access_ctrl

Overview:
- Sequencer between the core's load/store request port and the single-cycle LSU (data memory, output peripherals, switch input).
- Accepts one request at a time via valid/ready and normalises store data into byte lanes.
- Splits misaligned halfword/word accesses into sequential byte accesses, then merges and sign/zero-extends load results.
- Reports completion to the core with a one-cycle response pulse.

Parameters:
ADDR_W, 32, request/LSU address width; addresses wrap modulo 2^ADDR_W.

Ports:
clk_i  in  1  clock; all state updates on rising edge.
rst_ni  in  1  reset, synchronous, active-low.
req_valid_i  in  1  core request valid.
req_ready_o  out  1  controller can accept a request.
req_addr_i  in  ADDR_W  byte address.
req_we_i  in  1  1 = store, 0 = load.
req_mode_i  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu.
req_wdata_i  in  32  store data, right-justified.
rsp_valid_o  out  1  one-cycle completion pulse.
rsp_rdata_o  out  32  load result, extended; 0 for stores.
rsp_err_o  out  1  request rejected, no LSU access made.
lsu_addr_o  out  ADDR_W  to LSU addr_i.
lsu_st_en_o  out  1  to LSU st_en_i.
lsu_sel_mod_o  out  3  to LSU sel_mod.
lsu_st_data_o  out  32  to LSU st_data_i, lane-positioned.
lsu_ld_data_i  in  32  from LSU ld_data_o (combinational read).

Behaviour:
- All lsu_* and rsp_* outputs are registered.
- Reset values:
  - State IDLE; req_ready_o=1.
  - rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0.
  - lsu_st_en_o=0, lsu_addr_o=0, lsu_sel_mod_o=010, lsu_st_data_o=0.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=00. Byte accesses are never misaligned.
- Invalid mode (011, 110, 111) -> error response; no LSU access.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: req_ready_o=1. On valid&ready, latch the request and set N:
    - N=1 for aligned.
    - N=2 for misaligned halfword.
    - N=4 for misaligned word.
    - Invalid mode -> RESP with error flag set.
    - Otherwise -> ACCESS.
  - ACCESS: N cycles, index k=0..N-1, one LSU access per cycle.
    - Aligned: lsu_sel_mod_o=req mode, lsu_addr_o=addr.
    - Split: lsu_sel_mod_o=100 for loads, 000 for stores; lsu_addr_o=addr+k, wrapping.
    - Stores assert lsu_st_en_o=1 in every ACCESS cycle and drive 0 outside ACCESS.
    - Load data is sampled at the end of each ACCESS cycle. Split byte k goes to result bits [8k+7:8k].
    - After the last k -> RESP.
  - RESP: exactly 1 cycle, then IDLE.
    - rsp_valid_o=1; rsp_err_o as flagged.
    - rsp_rdata_o for loads: aligned = LSU data passed through; split = merged bytes sign-extended for mode 001, zero-extended for 101, raw for 010.
    - rsp_rdata_o for stores: 0.
- Store lane packing:
  - byte -> {4{wdata[7:0]}}.
  - half -> {2{wdata[15:0]}}.
  - word -> wdata.
  - split byte k -> {4{wdata[8k+7:8k]}}.
- Latency from the accept edge: rsp_valid_o rises N+1 cycles later. Error path: 1 cycle.
- Throughput: req_ready_o=0 in ACCESS and RESP. Next accept is possible in the cycle after RESP.
- Split accesses may cross an LSU region boundary (e.g. 0x3FF -> 0x400). Each byte goes to its own region; no special handling.
- Reset asserted mid-operation: the next edge returns to IDLE with lsu_st_en_o=0 and no rsp pulse. Bytes already stored stay committed.
- req_* inputs are ignored outside IDLE.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined: a misaligned request is not split. It goes IDLE -> RESP with rsp_err_o=1 and no LSU access (latency 1).
- Undefined: misaligned requests are split as above, and rsp_err_o is raised only for invalid modes.

Decomposition:
- Package lsu_ctrl_pkg:
  - Mode constants (MODE_B, MODE_H, MODE_W, MODE_BU, MODE_HU).
  - State enum.
  - Byte-count typedef for N and k (3 bits).
- Sub-module lsu_lane_pack (combinational):
  - Store lane replication from mode/k.
  - Load byte merge and sign/zero extension.

Test Plan:
- Aligned lw at 0x010, memory word 0xDEADBEEF -> one access with sel 010; rsp_valid 2 cycles after accept; rdata 0xDEADBEEF.
- Misaligned sw at 0x013, data 0x11223344 -> four st_en cycles at 0x013..0x016, data lanes 44,33,22,11 replicated; rsp at accept+5 with rdata 0. A following lw at 0x013 returns 0x11223344.
- Misaligned lh at 0x001 over bytes 0x80,0xFF -> 0xFFFFFF80 sign-extended (byte at 0x001 = 0x80, byte at 0x002 = 0xFF). lhu at the same address -> 0x0000FF80.
- Aligned sb at 0x402 (output peripheral region) with data 0xA5 -> lsu_st_data_o=0xA5A5A5A5, sel 000; hex0 output then reads 0x00A50000.
- Invalid mode 011 -> rsp_err_o=1 one cycle after accept; no st_en. With MISALIGN_TRAP_EN, lw at 0x002 -> error pulse and no LSU access.
- rst_ni low during the 2nd byte of a split sw -> IDLE next edge; st_en 0; no rsp; req_ready_o=1.

Source files
------------

// File: rtl/lsu_ctrl_pkg.sv
// rtl/lsu_ctrl_pkg.sv - shared modes, FSM states and count type for the LSU access controller
package lsu_ctrl_pkg;

    localparam logic [2:0] MODE_B  = 3'b000;
    localparam logic [2:0] MODE_H  = 3'b001;
    localparam logic [2:0] MODE_W  = 3'b010;
    localparam logic [2:0] MODE_BU = 3'b100;
    localparam logic [2:0] MODE_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_t;

    // Holds both the access count N and the running byte index k.
    typedef logic [2:0] cnt_t;

    function automatic logic mode_is_valid(input logic [2:0] mode);
        return (mode == MODE_B) || (mode == MODE_H) || (mode == MODE_W) ||
               (mode == MODE_BU) || (mode == MODE_HU);
    endfunction

endpackage

// File: rtl/lsu_lane_pack.sv
// rtl/lsu_lane_pack.sv - store lane replication and split-load byte merge/extension
module lsu_lane_pack
    import lsu_ctrl_pkg::*;
(
    input  logic [2:0]  mode,
    input  logic        split,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] merged,
    output logic [31:0] st_data,
    output logic [31:0] ld_data
);

    logic [7:0] split_byte;

    // Replicate the store data across all byte lanes so the LSU can pick any lane.
    always_comb begin
        split_byte = wdata[{lane, 3'b000} +: 8];
        st_data    = wdata;
        if (split) begin
            st_data = {4{split_byte}};
        end else begin
            case (mode)
                MODE_B:  st_data = {4{wdata[7:0]}};
                MODE_H:  st_data = {2{wdata[15:0]}};
                default: st_data = wdata;
            endcase
        end
    end

    // Split loads collect raw bytes; halfwords need their extension applied here.
    always_comb begin
        ld_data = merged;
        if (split) begin
            case (mode)
                MODE_H:  ld_data = {{16{merged[15]}}, merged[15:0]};
                MODE_HU: ld_data = {16'h0000, merged[15:0]};
                default: ld_data = merged;
            endcase
        end
    end

endmodule

// File: rtl/lsu_access_ctrl.sv
// rtl/lsu_access_ctrl.sv - request sequencer for the LSU; MISALIGN_TRAP_EN turns misaligned splits into errors
module lsu_access_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic              req_we_i,
    input  logic [2:0]        req_mode_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o,
    output logic [ADDR_W-1:0] lsu_addr_o,
    output logic              lsu_st_en_o,
    output logic [2:0]        lsu_sel_mod_o,
    output logic [31:0]       lsu_st_data_o,
    input  logic [31:0]       lsu_ld_data_i
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t      state;
    cnt_t        n_q;
    cnt_t        k_q;
    logic        we_q;
    logic        split_q;
    logic        err_q;
    logic [2:0]  mode_q;
    logic [31:0] wdata_q;
    logic [31:0] data_q;

    logic        req_mode_ok;
    logic        req_misaligned;
    logic        pk_split;
    logic [2:0]  pk_mode;
    logic [1:0]  pk_lane;
    logic [31:0] pk_wdata;
    logic [31:0] pk_st_data;
    logic [31:0] pk_ld_data;
    cnt_t        k_next;

    assign req_ready_o    = (state == ST_IDLE);
    assign req_mode_ok    = mode_is_valid(req_mode_i);
    assign req_misaligned = ((req_mode_i[1:0] == 2'b01) && req_addr_i[0]) ||
                            ((req_mode_i == MODE_W) && (req_addr_i[1:0] != 2'b00));
    assign k_next         = k_q + 3'd1;

    // In IDLE the packer sees the incoming request (byte 0); later it sees the latched one (next byte).
    always_comb begin
        pk_split = split_q;
        pk_mode  = mode_q;
        pk_lane  = k_next[1:0];
        pk_wdata = wdata_q;
        if (state == ST_IDLE) begin
            pk_split = req_misaligned;
            pk_mode  = req_mode_i;
            pk_lane  = 2'b00;
            pk_wdata = req_wdata_i;
        end
    end

    lsu_lane_pack u_lane_pack (
        .mode    (pk_mode),
        .split   (pk_split),
        .lane    (pk_lane),
        .wdata   (pk_wdata),
        .merged  (data_q),
        .st_data (pk_st_data),
        .ld_data (pk_ld_data)
    );

    // Sequencer: accept, issue N LSU accesses, then one response pulse.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state         <= ST_IDLE;
            n_q           <= 3'd1;
            k_q           <= 3'd0;
            we_q          <= 1'b0;
            split_q       <= 1'b0;
            err_q         <= 1'b0;
            mode_q        <= MODE_W;
            wdata_q       <= 32'h0;
            data_q        <= 32'h0;
            rsp_valid_o   <= 1'b0;
            rsp_err_o     <= 1'b0;
            rsp_rdata_o   <= 32'h0;
            lsu_addr_o    <= '0;
            lsu_st_en_o   <= 1'b0;
            lsu_sel_mod_o <= MODE_W;
            lsu_st_data_o <= 32'h0;
        end else begin
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        we_q    <= req_we_i;
                        mode_q  <= req_mode_i;
                        wdata_q <= req_wdata_i;
                        data_q  <= 32'h0;
                        k_q     <= 3'd0;
                        split_q <= 1'b0;
                        n_q     <= 3'd1;
                        if (!req_mode_ok) begin
                            err_q <= 1'b1;
                            state <= ST_RESP;
                        end else if (req_misaligned) begin
`ifdef MISALIGN_TRAP_EN
                            err_q <= 1'b1;
                            state <= ST_RESP;
`else
                            split_q       <= 1'b1;
                            n_q           <= (req_mode_i == MODE_W) ? 3'd4 : 3'd2;
                            state         <= ST_ACCESS;
                            lsu_addr_o    <= req_addr_i;
                            lsu_sel_mod_o <= req_we_i ? MODE_B : MODE_BU;
                            lsu_st_en_o   <= req_we_i;
                            lsu_st_data_o <= req_we_i ? pk_st_data : 32'h0;
`endif
                        end else begin
                            state         <= ST_ACCESS;
                            lsu_addr_o    <= req_addr_i;
                            lsu_sel_mod_o <= req_mode_i;
                            lsu_st_en_o   <= req_we_i;
                            lsu_st_data_o <= req_we_i ? pk_st_data : 32'h0;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (split_q) begin
                        data_q[{k_q[1:0], 3'b000} +: 8] <= lsu_ld_data_i[7:0];
                    end else begin
                        data_q <= lsu_ld_data_i;
                    end
                    if (k_q == n_q - 3'd1) begin
                        state       <= ST_RESP;
                        lsu_st_en_o <= 1'b0;
                    end else begin
                        k_q           <= k_next;
                        lsu_addr_o    <= lsu_addr_o + ADDR_ONE;
                        lsu_st_data_o <= we_q ? pk_st_data : 32'h0;
                    end
                end
                ST_RESP: begin
                    rsp_valid_o <= 1'b1;
                    rsp_err_o   <= err_q;
                    rsp_rdata_o <= (we_q || err_q) ? 32'h0 : pk_ld_data;
                    err_q       <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
